mem_access_ctrl: RTL and testbench

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

---
 rtl/mem_access_ctrl.sv | 174 +++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// Load/store access controller between the MEM stage and a handshaked data SRAM.
// Optional feature: define MEM_CTRL_ALIGN_CHECK_EN to fail misaligned half/word requests without touching the SRAM.
module mem_access_ctrl #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_sign,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall_req,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        data_sram_en,
  output logic [3:0]  data_sram_wen,
  output logic [31:0] data_sram_addr,
  output logic [31:0] data_sram_wdata,
  input  logic        sram_addr_ok,
  input  logic        sram_data_ok,
  input  logic [31:0] sram_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_DONE} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYC - 1);

  state_t      state_q, state_d;
  logic        we_q, sign_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q, wdata_q;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        accept, misaligned;
  logic [31:0] shifted, load_data;
  logic [3:0]  lane_wen;
  logic [31:0] lane_wdata;

  assign accept = (state_q == S_IDLE) && req_valid;

`ifdef MEM_CTRL_ALIGN_CHECK_EN
  // Size 3 is treated as a word, so req_size[1] covers both word encodings.
  assign misaligned = ((req_size == 2'd1) && req_addr[0]) ||
                      (req_size[1] && (req_addr[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  // Load alignment and extension, from the latched request and the raw SRAM word.
  always_comb begin
    // NOTE: every variable written here gets a default first so no latch is inferred.
    shifted   = sram_rdata;
    load_data = sram_rdata;
    case (size_q)
      2'd0: begin
        shifted   = sram_rdata >> {addr_q[1:0], 3'b000};
        load_data = {{24{sign_q & shifted[7]}}, shifted[7:0]};
      end
      2'd1: begin
        shifted   = sram_rdata >> {addr_q[1], 4'b0000};
        load_data = {{16{sign_q & shifted[15]}}, shifted[15:0]};
      end
      default: load_data = shifted;
    endcase
    if (we_q) load_data = '0;
  end

  // Store lane enables and replicated write data.
  always_comb begin
    lane_wen   = 4'b0000;
    lane_wdata = wdata_q;
    case (size_q)
      2'd0: begin
        lane_wen   = 4'b0001 << addr_q[1:0];
        lane_wdata = {4{wdata_q[7:0]}};
      end
      2'd1: begin
        lane_wen   = 4'b0011 << {addr_q[1], 1'b0};
        lane_wdata = {2{wdata_q[15:0]}};
      end
      default: lane_wen = 4'b1111;
    endcase
    if (!we_q) lane_wen = 4'b0000;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          if (misaligned) begin
            state_d = S_DONE;
            rdata_d = '0;
            err_d   = 1'b1;
          end else begin
            state_d = S_ADDR;
          end
        end
      end
      S_ADDR: begin
        if (sram_addr_ok) begin
          if (sram_data_ok) begin
            state_d = S_DONE;
            rdata_d = load_data;
            err_d   = 1'b0;
          end else begin
            state_d = S_DATA;
            cnt_d   = '0;
          end
        end
      end
      S_DATA: begin
        if (sram_data_ok) begin
          state_d = S_DONE;
          rdata_d = load_data;
          err_d   = 1'b0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_DONE;
          rdata_d = '0;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      sign_q  <= 1'b0;
      size_q  <= 2'd0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      if (accept) begin
        we_q    <= req_we;
        sign_q  <= req_sign;
        size_q  <= req_size;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
    end
  end

  // The IDLE term is gated by rst so the pipeline is never stalled during reset.
  assign stall_req       = rst & (accept | (state_q == S_ADDR) | (state_q == S_DATA));
  assign resp_valid      = (state_q == S_DONE);
  assign resp_rdata      = rdata_q;
  assign resp_err        = err_q;
  assign data_sram_en    = (state_q == S_ADDR);
  assign data_sram_wen   = data_sram_en ? lane_wen : 4'b0000;
  assign data_sram_addr  = data_sram_en ? {addr_q[31:2], 2'b00} : 32'h0;
  assign data_sram_wdata = data_sram_en ? lane_wdata : 32'h0;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed testbench for mem_access_ctrl, built with TIMEOUT_CYC=4; a responder task plays the SRAM handshake.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0, req_we = 1'b0, req_sign = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        stall_req, resp_valid, resp_err, data_sram_en;
  logic [31:0] resp_rdata, data_sram_addr, data_sram_wdata;
  logic [3:0]  data_sram_wen;
  logic        sram_addr_ok = 1'b0, sram_data_ok = 1'b0;
  logic [31:0] sram_rdata = '0;

  int n_tests = 0;
  int n_fail  = 0;

  // Observations from the most recent transaction.
  int          obs_en, obs_data, obs_stall;
  logic        obs_stall_first, obs_first_en, obs_done, obs_err, obs_err_after, obs_valid_after, obs_stall_done;
  logic [31:0] obs_rdata, obs_rdata_after, obs_addr, obs_wdata;
  logic [3:0]  obs_wen;

  mem_access_ctrl #(.TIMEOUT_CYC(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_we(req_we), .req_size(req_size), .req_sign(req_sign),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .stall_req(stall_req), .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .data_sram_en(data_sram_en), .data_sram_wen(data_sram_wen), .data_sram_addr(data_sram_addr),
    .data_sram_wdata(data_sram_wdata),
    .sram_addr_ok(sram_addr_ok), .sram_data_ok(sram_data_ok), .sram_rdata(sram_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // addr_lat: ADDR cycles before addr_ok; data_lat: -1 = with addr_ok, -2 = never, k = k-th DATA cycle.
  // b2b=1 issues the request in the IDLE cycle left current by the previous call.
  task automatic run_txn(input logic b2b, input logic we, input logic [1:0] size, input logic sign,
                         input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] rdata,
                         input int addr_lat, input int data_lat);
    obs_en = 0; obs_data = 0; obs_stall = 0; obs_done = 1'b0; obs_first_en = 1'b0;
    obs_addr = '0; obs_wen = '0; obs_wdata = '0; obs_rdata = '0; obs_err = 1'b0; obs_stall_done = 1'b0;
    if (!b2b) @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = size; req_sign = sign; req_addr = addr; req_wdata = wdata;
    #1;
    obs_stall_first = stall_req;
    if (stall_req) obs_stall++;
    @(negedge clk);
    req_valid = 1'b0;
    req_we = 1'($urandom); req_size = 2'($urandom); req_sign = 1'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
    #1;
    obs_first_en = data_sram_en;
    for (int c = 0; c < 300; c++) begin
      sram_addr_ok = 1'b0; sram_data_ok = 1'b0; sram_rdata = 32'h5A5A_5A5A;
      if (resp_valid) begin
        obs_done = 1'b1; obs_rdata = resp_rdata; obs_err = resp_err; obs_stall_done = stall_req;
        break;
      end
      if (stall_req) obs_stall++;
      if (data_sram_en) begin
        obs_en++;
        if (obs_en == 1) begin obs_addr = data_sram_addr; obs_wen = data_sram_wen; obs_wdata = data_sram_wdata; end
        if (obs_en > addr_lat) begin
          sram_addr_ok = 1'b1;
          if (data_lat == -1) sram_data_ok = 1'b1;
        end
      end else if (stall_req) begin
        obs_data++;
        if (obs_data == data_lat) sram_data_ok = 1'b1;
      end
      if (sram_data_ok) sram_rdata = rdata;
      @(negedge clk); #1;
    end
    sram_addr_ok = 1'b0; sram_data_ok = 1'b0;
    @(negedge clk); #1;
    obs_valid_after = resp_valid; obs_rdata_after = resp_rdata; obs_err_after = resp_err;
  endtask

  task automatic test_reset();
    rst = 1'b0; req_valid = 1'b1; sram_addr_ok = 1'b1; sram_data_ok = 1'b1; sram_rdata = 32'hFFFF_FFFF;
    @(negedge clk); #1;
    n_tests++;
    if ({stall_req, resp_valid, resp_err, data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata, resp_rdata} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: stall=%b valid=%b err=%b en=%b wen=%b addr=%h wdata=%h rdata=%h, all required 0",
               stall_req, resp_valid, resp_err, data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata, resp_rdata);
    end
    @(negedge clk);
    rst = 1'b1; req_valid = 1'b0; sram_addr_ok = 1'b0; sram_data_ok = 1'b0;
    #1;
    n_tests++;
    if ({stall_req, resp_valid, data_sram_en} !== 3'b000) begin
      n_fail++; $display("FAIL reset_idle: stall/valid/en=%b required 000", {stall_req, resp_valid, data_sram_en});
    end
  endtask

  task automatic test_load_word();
    run_txn(1'b0, 1'b0, 2'd2, 1'b0, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 2, 3);
    n_tests++; if (obs_stall_first !== 1'b1) begin n_fail++; $display("FAIL ldw_stall_idle: got %b required 1", obs_stall_first); end
    n_tests++; if (obs_en !== 3) begin n_fail++; $display("FAIL ldw_en_cycles: got %0d required 3", obs_en); end
    n_tests++; if (obs_data !== 3) begin n_fail++; $display("FAIL ldw_data_cycles: got %0d required 3", obs_data); end
    n_tests++; if (obs_stall !== 7) begin n_fail++; $display("FAIL ldw_stall_cycles: got %0d required 7", obs_stall); end
    n_tests++; if (obs_addr !== 32'h0000_0100) begin n_fail++; $display("FAIL ldw_addr: got %h required 00000100", obs_addr); end
    n_tests++; if (obs_wen !== 4'b0000) begin n_fail++; $display("FAIL ldw_wen: got %b required 0000", obs_wen); end
    n_tests++; if (obs_done !== 1'b1) begin n_fail++; $display("FAIL ldw_done: no resp_valid within bound"); end
    n_tests++; if (obs_rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL ldw_rdata: got %h required deadbeef", obs_rdata); end
    n_tests++; if (obs_err !== 1'b0) begin n_fail++; $display("FAIL ldw_err: got %b required 0", obs_err); end
    n_tests++; if (obs_stall_done !== 1'b0) begin n_fail++; $display("FAIL ldw_stall_done: got %b required 0", obs_stall_done); end
    n_tests++; if (obs_valid_after !== 1'b0) begin n_fail++; $display("FAIL ldw_valid_one_cycle: got %b required 0", obs_valid_after); end
    n_tests++; if (obs_rdata_after !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL ldw_rdata_hold: got %h required deadbeef", obs_rdata_after); end
  endtask

  task automatic test_load_lanes();
    logic [31:0] t_addr [5] = '{32'h203, 32'h203, 32'h201, 32'h202, 32'h200};
    logic [1:0]  t_size [5] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1};
    logic        t_sign [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [31:0] t_exp  [5] = '{32'hFFFF_FF80, 32'h0000_0080, 32'h0000_0022, 32'hFFFF_8011, 32'h0000_2233};
    for (int i = 0; i < 5; i++) begin
      run_txn(1'b0, 1'b0, t_size[i], t_sign[i], t_addr[i], 32'h0, 32'h8011_2233, 0, 1);
      n_tests++;
      if (obs_rdata !== t_exp[i] || obs_err !== 1'b0) begin
        n_fail++; $display("FAIL load_lane[%0d]: rdata=%h err=%b required rdata=%h err=0", i, obs_rdata, obs_err, t_exp[i]);
      end
    end
  endtask

  task automatic test_store();
    logic [31:0] t_addr  [5] = '{32'h302, 32'h101, 32'h300, 32'h104, 32'h108};
    logic [1:0]  t_size  [5] = '{2'd1, 2'd0, 2'd1, 2'd2, 2'd3};
    logic [31:0] t_wd    [5] = '{32'h0000_ABCD, 32'h1234_56EF, 32'h9999_ABCD, 32'hCAFE_BABE, 32'h0123_4567};
    logic [3:0]  t_wen   [5] = '{4'b1100, 4'b0010, 4'b0011, 4'b1111, 4'b1111};
    logic [31:0] t_ewd   [5] = '{32'hABCD_ABCD, 32'hEFEF_EFEF, 32'hABCD_ABCD, 32'hCAFE_BABE, 32'h0123_4567};
    logic [31:0] t_eaddr [5] = '{32'h300, 32'h100, 32'h300, 32'h104, 32'h108};
    for (int i = 0; i < 5; i++) begin
      run_txn(1'b0, 1'b1, t_size[i], 1'b0, t_addr[i], t_wd[i], 32'hFFFF_FFFF, 1, 1);
      n_tests++;
      if (obs_wen !== t_wen[i] || obs_wdata !== t_ewd[i] || obs_addr !== t_eaddr[i]) begin
        n_fail++; $display("FAIL store_lane[%0d]: wen=%b wdata=%h addr=%h required wen=%b wdata=%h addr=%h",
                           i, obs_wen, obs_wdata, obs_addr, t_wen[i], t_ewd[i], t_eaddr[i]);
      end
      n_tests++;
      if (obs_rdata !== 32'h0 || obs_err !== 1'b0 || obs_en !== 2) begin
        n_fail++; $display("FAIL store_resp[%0d]: rdata=%h err=%b en_cycles=%0d required 00000000/0/2", i, obs_rdata, obs_err, obs_en);
      end
    end
  endtask

  task automatic test_same_cycle();
    run_txn(1'b0, 1'b0, 2'd2, 1'b0, 32'h0000_0140, 32'h0, 32'h1357_9BDF, 0, -1);
    n_tests++; if (obs_en !== 1 || obs_data !== 0) begin n_fail++; $display("FAIL same_cycle_path: en_cycles=%0d data_cycles=%0d required 1/0", obs_en, obs_data); end
    n_tests++; if (obs_rdata !== 32'h1357_9BDF) begin n_fail++; $display("FAIL same_cycle_rdata: got %h required 13579bdf", obs_rdata); end
  endtask

  task automatic test_timeout();
    run_txn(1'b0, 1'b0, 2'd2, 1'b0, 32'h0000_0600, 32'h0, 32'h0, 0, -2);
    n_tests++; if (obs_done !== 1'b1) begin n_fail++; $display("FAIL timeout_done: no resp_valid within bound"); end
    n_tests++; if (obs_data !== 4) begin n_fail++; $display("FAIL timeout_data_cycles: got %0d required 4", obs_data); end
    n_tests++; if (obs_err !== 1'b1 || obs_rdata !== 32'h0) begin n_fail++; $display("FAIL timeout_resp: err=%b rdata=%h required 1/00000000", obs_err, obs_rdata); end
    n_tests++; if (obs_err_after !== 1'b1) begin n_fail++; $display("FAIL timeout_err_hold: got %b required 1", obs_err_after); end
  endtask

  task automatic test_back_to_back();
    run_txn(1'b0, 1'b0, 2'd2, 1'b0, 32'h0000_0700, 32'h0, 32'h0102_0304, 1, 1);
    n_tests++; if (obs_rdata !== 32'h0102_0304 || obs_err !== 1'b0) begin n_fail++; $display("FAIL b2b_first: rdata=%h err=%b required 01020304/0", obs_rdata, obs_err); end
    run_txn(1'b1, 1'b1, 2'd0, 1'b0, 32'h0000_0703, 32'h0000_00A5, 32'h0, 0, -1);
    n_tests++; if (obs_first_en !== 1'b1) begin n_fail++; $display("FAIL b2b_accept: en after IDLE request=%b required 1", obs_first_en); end
    n_tests++; if (obs_wen !== 4'b1000 || obs_wdata !== 32'hA5A5_A5A5 || obs_addr !== 32'h700) begin
      n_fail++; $display("FAIL b2b_store: wen=%b wdata=%h addr=%h required 1000/a5a5a5a5/00000700", obs_wen, obs_wdata, obs_addr);
    end
  endtask

  task automatic test_reset_mid();
    run_txn(1'b0, 1'b0, 2'd2, 1'b0, 32'h0000_0400, 32'h0, 32'hCAFE_F00D, 0, 1);
    n_tests++; if (obs_rdata_after !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL rstmid_pre_rdata: got %h required cafef00d", obs_rdata_after); end
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_addr = 32'h500;
    @(negedge clk);
    req_valid = 1'b0; sram_addr_ok = 1'b1;
    @(negedge clk);
    sram_addr_ok = 1'b0; #1;
    n_tests++; if (stall_req !== 1'b1 || data_sram_en !== 1'b0) begin n_fail++; $display("FAIL rstmid_in_data: stall=%b en=%b required 1/0", stall_req, data_sram_en); end
    @(negedge clk);
    rst = 1'b0; req_valid = 1'b1; #1;
    n_tests++;
    if ({stall_req, resp_valid, resp_err, data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata, resp_rdata} !== '0) begin
      n_fail++; $display("FAIL rstmid_outputs: stall=%b valid=%b en=%b rdata=%h, all required 0", stall_req, resp_valid, data_sram_en, resp_rdata);
    end
    @(negedge clk);
    rst = 1'b1; req_valid = 1'b0; sram_data_ok = 1'b1; sram_rdata = 32'h1234_5678;
    @(negedge clk);
    sram_data_ok = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_tests++;
      if (resp_valid !== 1'b0 || stall_req !== 1'b0 || resp_rdata !== 32'h0 || resp_err !== 1'b0) begin
        n_fail++; $display("FAIL rstmid_late_data[%0d]: valid=%b stall=%b rdata=%h err=%b required 0/0/00000000/0", i, resp_valid, stall_req, resp_rdata, resp_err);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_misaligned();
    run_txn(1'b0, 1'b0, 2'd2, 1'b0, 32'h0000_0102, 32'h0, 32'h1122_3344, 0, 1);
`ifdef MEM_CTRL_ALIGN_CHECK_EN
    n_tests++; if (obs_en !== 0) begin n_fail++; $display("FAIL misalign_en: en_cycles=%0d required 0", obs_en); end
    n_tests++; if (obs_done !== 1'b1 || obs_err !== 1'b1 || obs_rdata !== 32'h0) begin
      n_fail++; $display("FAIL misalign_resp: done=%b err=%b rdata=%h required 1/1/00000000", obs_done, obs_err, obs_rdata);
    end
    run_txn(1'b0, 1'b1, 2'd1, 1'b0, 32'h0000_0101, 32'h0000_BEEF, 32'h0, 0, 1);
    n_tests++; if (obs_en !== 0 || obs_err !== 1'b1) begin n_fail++; $display("FAIL misalign_half: en_cycles=%0d err=%b required 0/1", obs_en, obs_err); end
`else
    n_tests++; if (obs_en !== 1 || obs_addr !== 32'h100) begin n_fail++; $display("FAIL unaligned_access: en_cycles=%0d addr=%h required 1/00000100", obs_en, obs_addr); end
    n_tests++; if (obs_err !== 1'b0 || obs_rdata !== 32'h1122_3344) begin
      n_fail++; $display("FAIL unaligned_resp: err=%b rdata=%h required 0/11223344", obs_err, obs_rdata);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_load_word();
    test_load_lanes();
    test_store();
    test_same_cycle();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    test_misaligned();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
